// File: rtl/sender_fifo.sv
// sender_fifo: word-wide transmit FIFO feeding a byte-serial UART sender.
// Each rising edge of start pushes one WORD_BYTES-byte word into a circular
// buffer of 2**DEPTH_LOG2 entries. A serializer drains the buffer one byte at
// a time through the valid/sender_ready handshake, in the byte order chosen
// by MSB_FIRST.
//
// Ports:
//   CLK          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   data         in   word sampled on a detected start rising edge
//   start        in   write strobe; only its 0->1 transition pushes
//   sender_ready in   1 = UART sender idle, 0 = sender busy
//   output_data  out  byte presented to the sender
//   valid        out  output_data holds a new byte
//   full         out  count == depth
//   empty        out  count == 0
//   count        out  stored words, including the word being serialized
//   overflow     out  sticky: a push was dropped because the FIFO was full
module sender_fifo #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [8*WORD_BYTES-1:0]   data,
    input  logic                      start,
    input  logic                      sender_ready,
    output logic [7:0]                output_data,
    output logic                      valid,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH_LOG2:0]       count,
    output logic                      overflow
);

    localparam int unsigned W  = 8 * WORD_BYTES;
    localparam int unsigned D  = 1 << DEPTH_LOG2;
    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam int unsigned BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_BUSY    = 2'd2
    } state_e;

    logic [W-1:0]          mem_q [D];

    state_e                state_q, state_d;
    logic                  start_q;
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         bi_q, bi_d;
    logic [7:0]            out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;

    logic                  full_c;
    logic                  push_c;
    logic                  push_ok_c;
    logic                  pop_c;
    logic [BW-1:0]         ld_idx_c;
    logic [W-1:0]          head_word_c;
    logic [7:0]            byte_c;

    // Push detection; fullness is judged on the registered count, before any pop.
    always_comb begin
        full_c    = (count_q == CW'(D));
        push_c    = start & ~start_q;
        push_ok_c = push_c & ~full_c;
    end

    // Byte to load next: byte 0 when starting a word, else the following byte.
    always_comb begin
        ld_idx_c    = (state_q == S_BUSY) ? (bi_q + BW'(1)) : '0;
        head_word_c = mem_q[head_q];
        byte_c      = '0;
        for (int b = 0; b < int'(WORD_BYTES); b++) begin
            if (ld_idx_c == BW'(b)) begin
                if (MSB_FIRST != 0) begin
                    byte_c = head_word_c[W-1-8*b -: 8];
                end else begin
                    byte_c = head_word_c[8*b +: 8];
                end
            end
        end
    end

    // Serializer next-state and output logic.
    always_comb begin
        state_d = state_q;
        bi_d    = bi_q;
        out_d   = out_q;
        valid_d = valid_q;
        head_d  = head_q;
        pop_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && sender_ready) begin
                    out_d   = byte_c;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (!sender_ready) begin
                    valid_d = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (sender_ready) begin
                    if (bi_q != BW'(WORD_BYTES - 1)) begin
                        bi_d    = ld_idx_c;
                        out_d   = byte_c;
                        valid_d = 1'b1;
                        state_d = S_PRESENT;
                    end else begin
                        // Word finished: only now does it leave the count.
                        pop_c   = 1'b1;
                        head_d  = head_q + DEPTH_LOG2'(1);
                        bi_d    = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pointer, count and sticky overflow bookkeeping.
    always_comb begin
        tail_d     = push_ok_c ? (tail_q + DEPTH_LOG2'(1)) : tail_q;
        count_d    = count_q + CW'(push_ok_c) - CW'(pop_c);
        overflow_d = overflow_q | (push_c & full_c);
    end

    // Control state registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            bi_q       <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            bi_q       <= bi_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Word storage; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (push_ok_c) begin
            mem_q[tail_q] <= data;
        end
    end

    assign output_data = out_q;
    assign valid       = valid_q;
    assign count       = count_q;
    assign full        = full_c;
    assign empty       = (count_q == '0);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sender_fifo.sv
// Bench for sender_fifo: two instances (4-byte MSB-first and 2-byte
// LSB-first, both depth 4) driven by directed and random pushes, each with an
// emulated UART sender; a word/byte queue model predicts count, status flags
// and the byte stream.
module tb_sender_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] dat [2];
    logic        st  [2];
    logic        rdy [2];
    logic [7:0]  od  [2];
    logic        vld [2];
    logic        ful [2];
    logic        emp [2];
    logic [2:0]  cnt [2];
    logic        ovf [2];

    sender_fifo #(.WORD_BYTES(4), .DEPTH_LOG2(2), .MSB_FIRST(1)) dut_a (
        .CLK(clk), .reset(rst), .data(dat[0]), .start(st[0]),
        .sender_ready(rdy[0]), .output_data(od[0]), .valid(vld[0]),
        .full(ful[0]), .empty(emp[0]), .count(cnt[0]), .overflow(ovf[0])
    );

    sender_fifo #(.WORD_BYTES(2), .DEPTH_LOG2(2), .MSB_FIRST(0)) dut_b (
        .CLK(clk), .reset(rst), .data(dat[1][15:0]), .start(st[1]),
        .sender_ready(rdy[1]), .output_data(od[1]), .valid(vld[1]),
        .full(ful[1]), .empty(emp[1]), .count(cnt[1]), .overflow(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int DEPTH = 4;
    int          wb  [2] = '{4, 2};
    bit          msb [2] = '{1'b1, 1'b0};

    int          checks = 0;
    int          errors = 0;

    // Reference model state.
    int          mcount [2];
    bit          movf   [2];
    logic [7:0]  expb   [2][256];
    int          rd     [2];
    int          wr     [2];
    // Emulated sender state.
    int          rxn    [2];
    int          rxtot  [2];
    logic [7:0]  rxlog  [2][256];
    bit          outst  [2];
    int          busy   [2];
    bit          hold   [2];
    // Stimulus state.
    bit          st_nxt  [2];
    bit          st_prev [2];
    logic [31:0] dnx     [2];
    bit          auto_on [2];
    int          auto_left [2];
    int          maxcnt  [2];

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s observed=%0h expected=%0h", d, tag, obs, exp);
        end
    endtask

    // One clock cycle: compare status, run the senders, apply the next start level.
    task automatic step();
        bit pop;
        bit push;
        int sh;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "count", 64'(cnt[d]), 64'(mcount[d]));
            chk(d, "full", 64'(ful[d]), 64'(mcount[d] == DEPTH));
            chk(d, "empty", 64'(emp[d]), 64'(mcount[d] == 0));
            chk(d, "overflow", 64'(ovf[d]), 64'(movf[d]));
            if (int'(cnt[d]) > maxcnt[d]) maxcnt[d] = int'(cnt[d]);
        end
        for (int d = 0; d < 2; d++) begin
            pop = 1'b0;
            if (rdy[d] && vld[d]) begin
                chk(d, "byte_expected", 64'(wr[d] != rd[d]), 64'(1));
                if (wr[d] != rd[d]) begin
                    chk(d, "byte", 64'(od[d]), 64'(expb[d][rd[d] % 256]));
                    rd[d]++;
                end
                rxlog[d][rxtot[d] % 256] = od[d];
                rxtot[d]++;
                rxn[d]++;
                outst[d] = 1'b1;
                rdy[d]   = 1'b0;
                busy[d]  = $urandom_range(1, 3);
            end else if (!rdy[d] && !hold[d]) begin
                if (busy[d] > 1) begin
                    busy[d]--;
                end else begin
                    rdy[d] = 1'b1;
                    if (outst[d] && (rxn[d] % wb[d] == 0)) pop = 1'b1;
                    outst[d] = 1'b0;
                end
            end
            if (hold[d]) rdy[d] = 1'b0;

            if (auto_on[d]) begin
                st_nxt[d] = pop && (auto_left[d] > 0);
                if (st_nxt[d]) begin
                    dnx[d] = $urandom;
                    auto_left[d]--;
                end
            end

            push = st_nxt[d] && !st_prev[d];
            st[d]  = st_nxt[d];
            dat[d] = dnx[d];
            st_prev[d] = st_nxt[d];
            if (push) begin
                if (mcount[d] < DEPTH) begin
                    for (int b = 0; b < wb[d]; b++) begin
                        sh = msb[d] ? 8 * (wb[d] - 1 - b) : 8 * b;
                        expb[d][wr[d] % 256] = 8'(dnx[d] >> sh);
                        wr[d]++;
                    end
                    mcount[d]++;
                end else begin
                    movf[d] = 1'b1;
                end
            end
            if (pop) mcount[d]--;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; st_nxt[d] = 1'b0; st_prev[d] = 1'b0;
            hold[d] = 1'b0; auto_on[d] = 1'b0; auto_left[d] = 0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_valid", 64'(vld[d]), 64'(0));
            chk(d, "rst_count", 64'(cnt[d]), 64'(0));
            chk(d, "rst_empty", 64'(emp[d]), 64'(1));
            chk(d, "rst_full", 64'(ful[d]), 64'(0));
            chk(d, "rst_overflow", 64'(ovf[d]), 64'(0));
            chk(d, "rst_output_data", 64'(od[d]), 64'(0));
            mcount[d] = 0; movf[d] = 1'b0; rd[d] = wr[d];
            rxn[d] = 0; outst[d] = 1'b0; busy[d] = 0; rdy[d] = 1'b1;
            maxcnt[d] = 0;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input int d, input logic [31:0] w);
        st_nxt[d] = 1'b1;
        dnx[d] = w;
        step();
        st_nxt[d] = 1'b0;
        step();
    endtask

    task automatic drain(input int d);
        int n = 0;
        while ((mcount[d] != 0 || rd[d] != wr[d]) && n < 2000) begin
            step();
            n++;
        end
        chk(d, "drain_in_time", 64'(n < 2000), 64'(1));
    endtask

    task automatic last_bytes(input int d, input string tag, input logic [31:0] w, input int nb);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < nb; i++) begin
            chk(d, tag, 64'(rxlog[d][(rxtot[d] - nb + i) % 256]), 64'(v[8*(nb-1-i) +: 8]));
        end
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            dat[d] = '0; dnx[d] = '0; rd[d] = 0; wr[d] = 0; rxtot[d] = 0;
        end
        do_reset();

        // Held-high start pushes exactly once.
        hold[0] = 1'b1;
        step();
        st_nxt[0] = 1'b1;
        dnx[0] = 32'hDEADBEEF;
        repeat (10) step();
        st_nxt[0] = 1'b0;
        step();
        chk(0, "held_start_count", 64'(cnt[0]), 64'(1));
        hold[0] = 1'b0;
        drain(0);

        // Single word with push-to-valid latency.
        st_nxt[0] = 1'b1;
        dnx[0] = 32'h11223344;
        step();
        st_nxt[0] = 1'b0;
        step();
        chk(0, "latency_valid_low", 64'(vld[0]), 64'(0));
        step();
        chk(0, "latency_valid_high", 64'(vld[0]), 64'(1));
        chk(0, "first_byte", 64'(od[0]), 64'(8'h11));
        drain(0);
        last_bytes(0, "msb_order", 32'h11223344, 4);

        // Two-byte LSB-first instance.
        push(1, 32'h0000ABCD);
        drain(1);
        last_bytes(1, "lsb_order", 32'h0000CDAB, 2);

        // Fill with sender busy, then overflow.
        hold[0] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) push(0, $urandom);
        chk(0, "fill_full", 64'(ful[0]), 64'(1));
        chk(0, "fill_count", 64'(cnt[0]), 64'(4));
        push(0, 32'hBAD0BAD0);
        chk(0, "ovf_count", 64'(cnt[0]), 64'(4));
        chk(0, "ovf_set", 64'(ovf[0]), 64'(1));
        hold[0] = 1'b0;
        drain(0);
        chk(0, "ovf_sticky", 64'(ovf[0]), 64'(1));

        // Wrap: push on every pop, ten words total.
        do_reset();
        hold[0] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) push(0, $urandom);
        auto_left[0] = 7;
        auto_on[0] = 1'b1;
        hold[0] = 1'b0;
        n = 0;
        while (auto_left[0] > 0 && n < 3000) begin
            step();
            n++;
        end
        chk(0, "stream_in_time", 64'(n < 3000), 64'(1));
        drain(0);
        auto_on[0] = 1'b0;
        chk(0, "stream_max_count", 64'(maxcnt[0] <= DEPTH), 64'(1));
        chk(0, "stream_bytes", 64'(rxn[0]), 64'(40));
        chk(0, "stream_no_overflow", 64'(ovf[0]), 64'(0));

        // Random traffic on both instances.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int d = 0; d < 2; d++) begin
                st_nxt[d] = ($urandom_range(0, 2) == 0);
                dnx[d] = $urandom;
            end
            step();
        end
        st_nxt[0] = 1'b0;
        st_nxt[1] = 1'b0;
        drain(0);
        drain(1);

        // Reset after two bytes of a word.
        do_reset();
        push(0, $urandom);
        n = 0;
        while (rxn[0] < 2 && n < 200) begin
            step();
            n++;
        end
        chk(0, "midword_reached", 64'(rxn[0]), 64'(2));
        do_reset();
        push(0, 32'hCAFEF00D);
        drain(0);
        last_bytes(0, "post_reset_word", 32'hCAFEF00D, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
